// File: rtl/uart_pkg.sv
// Shared UART definitions: FIFO defaults and the FIFO status snapshot struct.
package uart_pkg;

  localparam int UART_FIFO_DEPTH_DEFAULT  = 16;
  localparam int UART_FIFO_DATA_W_DEFAULT = 8;
  // Wide enough to carry the occupancy of any practical FIFO depth.
  localparam int UART_FIFO_STATUS_CNT_W   = 16;

  typedef struct packed {
    logic                              full;
    logic                              empty;
    logic                              almost_full;
    logic [UART_FIFO_STATUS_CNT_W-1:0] count;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_if.sv
// Host/UART-side handshake bundle for uart_fifo. Error-flag signals exist only
// when UART_FIFO_ERR_FLAGS_EN is defined.
interface uart_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_FIFO_DATA_W_DEFAULT,
  parameter int ADDR_W = $clog2(UART_FIFO_DEPTH_DEFAULT)
);
  // Strobe semantics: push_i/pop_i are per-cycle requests with no ready; a push
  // is taken unless full (or full with an accepted pop), a pop unless empty.
  // pop_data_o is the head entry and is valid whenever empty_o is low.
  logic              flush_i;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic [ADDR_W:0]   count_o;
  uart_fifo_status_t status_o;
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic              overflow_o;
  logic              underflow_o;
  logic              clr_err_i;
`endif

  modport master (
    output flush_i, push_i, push_data_i, pop_i,
`ifdef UART_FIFO_ERR_FLAGS_EN
    output clr_err_i,
    input  overflow_o, underflow_o,
`endif
    input  pop_data_o, full_o, empty_o, almost_full_o, count_o, status_o
  );

  modport slave (
    input  flush_i, push_i, push_data_i, pop_i,
`ifdef UART_FIFO_ERR_FLAGS_EN
    input  clr_err_i,
    output overflow_o, underflow_o,
`endif
    output pop_data_o, full_o, empty_o, almost_full_o, count_o, status_o
  );

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for the UART host side. Optional sticky
// overflow/underflow flags are enabled by UART_FIFO_ERR_FLAGS_EN.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_FIFO_DATA_W_DEFAULT,
  parameter int DEPTH        = UART_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic        clk_i,
  input logic        rst_i,
  uart_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   AFULL_C = AFULL_THRESH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic              push_acc, pop_acc;

  // Pop is decided first: a full FIFO can still take a push if the head leaves.
  assign pop_acc  = bus.pop_i && !empty_q;
  assign push_acc = bus.push_i && (!full_q || pop_acc);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q] = bus.push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop_acc);
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afull_d = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
    end
  end

  assign bus.pop_data_o    = mem_q[rd_ptr_q];
  assign bus.full_o        = full_q;
  assign bus.empty_o       = empty_q;
  assign bus.almost_full_o = afull_q;
  assign bus.count_o       = count_q;
  assign bus.status_o      = '{full: full_q, empty: empty_q, almost_full: afull_q,
                               count: UART_FIFO_STATUS_CNT_W'(count_q)};

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A set event in the same cycle beats clr_err_i; flush beats everything.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.clr_err_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.push_i && !push_acc) ovf_d = 1'b1;
    if (bus.pop_i && !pop_acc)   udf_d = 1'b1;
    if (bus.flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: vector table for fill/drain/simultaneous cases,
// hand sequences for wrap-around, flush, reset and the optional error flags.
module tb_uart_fifo;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  uart_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_THRESH(DEPTH-2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       flush;
    logic       push;
    logic [7:0] data;
    logic       pop;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_afull;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  logic [DATA_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic push, input logic [7:0] data, input logic pop,
                         input int cnt, input logic chk, input logic [7:0] head);
    vec_t v;
    v.flush = 1'b0; v.push = push; v.data = data; v.pop = pop;
    v.exp_count = cnt;
    v.exp_empty = (cnt == 0);
    v.exp_full  = (cnt == DEPTH);
    v.exp_afull = (cnt >= DEPTH - 2);
    v.chk_data  = chk;
    v.exp_data  = head;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.flush_i     = 1'b0;
    bus.push_i      = 1'b0;
    bus.pop_i       = 1'b0;
    bus.push_data_i = '0;
`ifdef UART_FIFO_ERR_FLAGS_EN
    bus.clr_err_i   = 1'b0;
`endif
  endtask

  task automatic step(input logic push, input logic [7:0] data, input logic pop, input logic flush);
    bus.push_i = push; bus.push_data_i = data; bus.pop_i = pop; bus.flush_i = flush;
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic check_status(input string tag, input int cnt);
    check({tag, "_count"}, int'(bus.count_o), cnt);
    check({tag, "_empty"}, int'(bus.empty_o), int'(cnt == 0));
    check({tag, "_full"},  int'(bus.full_o),  int'(cnt == DEPTH));
    check({tag, "_afull"}, int'(bus.almost_full_o), int'(cnt >= DEPTH - 2));
  endtask

  initial begin
    idle_inputs();

    // Vector table: fill 0x11..0x20, dropped 0xFF, drain, full/empty push+pop.
    for (int i = 1; i <= 15; i++) add_vec(1'b1, 8'(8'h10 + i), 1'b0, i, 1'b1, 8'h11);
    add_vec(1'b1, 8'h20, 1'b0, 16, 1'b1, 8'h11);
    add_vec(1'b1, 8'hFF, 1'b0, 16, 1'b1, 8'h11);
    for (int k = 0; k < 16; k++) add_vec(1'b0, 8'h00, 1'b1, 15 - k, (k < 15), 8'(8'h12 + k));
    for (int i = 0; i < 16; i++) add_vec(1'b1, 8'(8'h30 + i), 1'b0, i + 1, 1'b1, 8'h30);
    add_vec(1'b1, 8'h50, 1'b1, 16, 1'b1, 8'h31);
    for (int j = 0; j < 16; j++)
      add_vec(1'b0, 8'h00, 1'b1, 15 - j, (j < 15), (j < 14) ? 8'(8'h32 + j) : 8'h50);
    add_vec(1'b1, 8'h77, 1'b1, 1, 1'b1, 8'h77);
    add_vec(1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00);

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_status("reset", 0);
    check("reset_data", int'(bus.pop_data_o), 0);
    check("reset_status_struct", int'(bus.status_o.count), 0);
`ifdef UART_FIFO_ERR_FLAGS_EN
    check("reset_ovf", int'(bus.overflow_o), 0);
    check("reset_udf", int'(bus.underflow_o), 0);
`endif

    foreach (vecs[n]) begin
      step(vecs[n].push, vecs[n].data, vecs[n].pop, vecs[n].flush);
      check($sformatf("vec%0d_count", n), int'(bus.count_o), vecs[n].exp_count);
      check($sformatf("vec%0d_empty", n), int'(bus.empty_o), int'(vecs[n].exp_empty));
      check($sformatf("vec%0d_full", n),  int'(bus.full_o),  int'(vecs[n].exp_full));
      check($sformatf("vec%0d_afull", n), int'(bus.almost_full_o), int'(vecs[n].exp_afull));
      if (vecs[n].chk_data)
        check($sformatf("vec%0d_data", n), int'(bus.pop_data_o), int'(vecs[n].exp_data));
    end

    // Wrap-around: 40 pushes with occupancy cycling 0..5 against a queue model.
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       do_pop;
      d      = 8'($urandom_range(0, 255));
      do_pop = (exp_q.size() > (i % 6));
      if (do_pop) check($sformatf("wrap%0d_head", i), int'(bus.pop_data_o), int'(exp_q[0]));
      step(1'b1, d, do_pop, 1'b0);
      if (do_pop) void'(exp_q.pop_front());
      exp_q.push_back(d);
      check($sformatf("wrap%0d_count", i), int'(bus.count_o), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      check("drain_head", int'(bus.pop_data_o), int'(exp_q[0]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    check_status("drain", 0);

    // Flush with a simultaneous push at count 7.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    check_status("pre_flush", 7);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_status("flush", 0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_flush_data", int'(bus.pop_data_o), 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation at count 9.
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check_status("pre_rst", 9);
    rst_i = 1'b1;
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    rst_i = 1'b0;
    check_status("rst", 0);
    check("rst_data", int'(bus.pop_data_o), 0);

`ifdef UART_FIFO_ERR_FLAGS_EN
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", int'(bus.underflow_o), 1);
    check("udf_ovf_clear", int'(bus.overflow_o), 0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", int'(bus.overflow_o), 1);
    check_status("ovf_state", DEPTH);
    bus.clr_err_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_ovf", int'(bus.overflow_o), 0);
    check("clr_udf", int'(bus.underflow_o), 0);
    bus.clr_err_i = 1'b1;
    step(1'b1, 8'hFE, 1'b0, 1'b0);
    check("clr_vs_set_ovf", int'(bus.overflow_o), 1);
    check("clr_vs_set_udf", int'(bus.underflow_o), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_clr_ovf", int'(bus.overflow_o), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous first-word-fall-through FIFO sitting on the host side of the UART controller's FIFO handshake. One instance feeds the Tx path and answers `tx_fifo_pop_o` with the next character. A second instance absorbs the Rx path on `rx_fifo_push_o` / `rx_data_o`. Host logic fills or drains the opposite port, and the block reports occupancy and full/empty status.

## Interface
- `DATA_W`, 8: width of one stored character; matches `MAX_UART_DATA_W`.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width.
- `AFULL_THRESH`, `DEPTH-2`: occupancy at or above which `almost_full_o` asserts.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: synchronous clear of contents; pointers and count go to 0.
- `push_i` in 1: write strobe, one entry per cycle high.
- `push_data_i` in `DATA_W`: write data.
- `pop_i` in 1: read strobe; consumes the head entry.
- `pop_data_o` out `DATA_W`: head entry; valid whenever `empty_o`=0.
- `full_o` out 1: count == `DEPTH`.
- `empty_o` out 1: count == 0.
- `almost_full_o` out 1: count ≥ `AFULL_THRESH`.
- `count_o` out `ADDR_W+1`: current occupancy, 0..`DEPTH`.
- `overflow_o`, `underflow_o`, `clr_err_i`: present only with `UART_FIFO_ERR_FLAGS_EN`.

## Operation
- Storage: `DEPTH` × `DATA_W` register array, write pointer `wr_ptr`, read pointer `rd_ptr`, and registered `count`.
- Pointers are `ADDR_W` bits wide and wrap naturally from `DEPTH-1` to 0.
- Push is accepted when `push_i` && (!full || pop accepted in the same cycle). On accept: `mem[wr_ptr]` ← data and `wr_ptr`++.
- Pop is accepted when `pop_i` && !empty. On accept: `rd_ptr`++.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Full with simultaneous push and pop: both are accepted, count stays `DEPTH`.
- Empty with simultaneous push and pop: the pop is ignored, the push is accepted, count → 1.
- Push while full without a pop: data is dropped and state is unchanged.
- Pop while empty: ignored; `pop_data_o` is undefined but stable.
- `flush_i` has priority over push and pop in the same cycle. The array contents are not cleared.
- There is no state machine; behaviour is pointer/count arithmetic only.

## Timing
- Reset values:
  - `count_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=0
  - `pop_data_o`=0 (the array is reset to 0)
  - `overflow_o`=0, `underflow_o`=0
- Status flags are registered and decoded from the next-state count, so they are exact in the cycle after the causing edge.
- Push into an empty FIFO at edge N: `empty_o`=0 and `pop_data_o`=data after edge N; the data is poppable at edge N+1.
- Pop at edge N: `pop_data_o` shows the next entry after edge N, so the head is combinational from `mem[rd_ptr]`.
- A pop asserted in the same cycle as `tx_fifo_pop_o` consumes the data presented in that cycle. Sustained throughput is one push and one pop per cycle.
- `rst_i` mid-operation discards all contents within one edge.

## Configuration
- Macro: `UART_FIFO_ERR_FLAGS_EN`.
- Defined:
  - Adds sticky `overflow_o`, set on a rejected push.
  - Adds sticky `underflow_o`, set on a rejected pop.
  - Adds `clr_err_i`, which clears both flags on the next edge. A set event in the same cycle wins over the clear.
  - `rst_i` and `flush_i` also clear both flags.
- Undefined: the three ports are absent; rejected operations are silent.

## Structure
- Shared `uart_pkg` holds:
  - `UART_FIFO_DEPTH_DEFAULT` (16)
  - the default `DATA_W` (8)
  - a `uart_fifo_status_t` struct: `{full, empty, almost_full, count}`
- Single module; no sub-module. A separate memory macro is not warranted at this depth.
- Tx instance: `pop_i` ← `tx_fifo_pop_o`, `tx_data_i` ← `pop_data_o`.
- Rx instance: `push_i` ← `rx_fifo_push_o`, `push_data_i` ← `rx_data_o`.

## Test plan
- Reset, then push 0x11..0x1F for 15 cycles:
  - `count_o` reaches 15; `almost_full_o`=1 from count 14; `full_o`=0.
- Push a 16th entry 0x20:
  - `full_o`=1.
  - A further push of 0xFF is dropped.
  - Popping 16 times returns 0x11..0x20 in order, then `empty_o`=1.
- Push and pop simultaneously while full, then while empty:
  - Full case: count stays 16.
  - Empty case: count becomes 1 and `pop_data_o` = the pushed value.
- Wrap-around over 40 push/pop pairs with interleaved occupancy 0..5:
  - Data order is preserved across the pointer wrap.
- Assert `flush_i` together with `push_i` at count 7:
  - count=0 and `empty_o`=1 next cycle.
  - Assert `rst_i` at count 9: same result.
- With `UART_FIFO_ERR_FLAGS_EN`:
  - Pop when empty → `underflow_o`=1.
  - Push when full → `overflow_o`=1.
  - `clr_err_i` clears both flags.
  - `clr_err_i` asserted together with a new overflow leaves `overflow_o`=1.
